// File: rtl/obi_mem_arbiter.sv
// Two-master OBI arbiter: instruction (M0) and data (M1) share one single-port OBI slave.
// Define OBI_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority with data over instruction.
module obi_mem_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    insn_req_i,
    output logic                    insn_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   insn_addr_i,
    output logic                    insn_rvalid_o,
    output logic [DATA_WIDTH-1:0]   insn_rdata_o,
    input  logic                    data_req_i,
    output logic                    data_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   data_addr_i,
    input  logic                    data_we_i,
    input  logic [DATA_WIDTH/8-1:0] data_be_i,
    input  logic [DATA_WIDTH-1:0]   data_wdata_i,
    output logic                    data_rvalid_o,
    output logic [DATA_WIDTH-1:0]   data_rdata_o,
    output logic                    mem_req_o,
    input  logic                    mem_gnt_i,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic                    mem_we_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic                    mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic {
        SEL_INSN = 1'b0,
        SEL_DATA = 1'b1
    } sel_e;

    sel_e             r_fifo [MAX_OUTSTANDING];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_lock;
    sel_e             r_lock_id;

    logic w_any_req;
    logic w_full;
    logic w_empty;
    logic w_hs;
    logic w_pop;
    sel_e w_arb_sel;
    sel_e w_sel;
    sel_e w_head;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
    endfunction

`ifdef OBI_ARB_ROUND_ROBIN_EN
    sel_e r_last;

    always_ff @(posedge clk_i) begin
        // Reset to M1 so that M0 wins the first conflict after reset.
        if (rst_i) begin
            r_last <= SEL_DATA;
        end else if (w_hs) begin
            r_last <= w_sel;
        end
    end

    always_comb begin
        w_arb_sel = data_req_i ? SEL_DATA : SEL_INSN;
        if (insn_req_i && data_req_i) begin
            w_arb_sel = (r_last == SEL_INSN) ? SEL_DATA : SEL_INSN;
        end
    end
`else
    always_comb begin
        w_arb_sel = data_req_i ? SEL_DATA : SEL_INSN;
    end
`endif

    assign w_any_req = insn_req_i | data_req_i;
    assign w_full    = (r_count == CNT_W'(MAX_OUTSTANDING));
    assign w_empty   = (r_count == '0);
    assign w_sel     = r_lock ? r_lock_id : w_arb_sel;
    assign w_hs      = mem_req_o & mem_gnt_i;
    assign w_pop     = mem_rvalid_i & ~w_empty;
    assign w_head    = r_fifo[r_rd_ptr];

    assign mem_req_o  = w_any_req & ~w_full;
    assign insn_gnt_o = w_hs & (w_sel == SEL_INSN);
    assign data_gnt_o = w_hs & (w_sel == SEL_DATA);

    assign insn_rvalid_o = w_pop & (w_head == SEL_INSN);
    assign data_rvalid_o = w_pop & (w_head == SEL_DATA);
    assign insn_rdata_o  = mem_rdata_i;
    assign data_rdata_o  = mem_rdata_i;

    // Address-phase outputs are zeroed when nobody requests so an idle bus is quiet.
    always_comb begin
        mem_addr_o  = '0;
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_wdata_o = '0;
        if (w_any_req) begin
            if (w_sel == SEL_DATA) begin
                mem_addr_o  = data_addr_i;
                mem_we_o    = data_we_i;
                mem_be_o    = data_be_i;
                mem_wdata_o = data_wdata_i;
            end else begin
                mem_addr_o  = insn_addr_i;
                mem_be_o    = '1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_lock    <= 1'b0;
            r_lock_id <= SEL_INSN;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
        end else begin
            if (w_hs) begin
                r_lock <= 1'b0;
            end else if (mem_req_o) begin
                r_lock    <= 1'b1;
                r_lock_id <= w_sel;
            end

            if (w_hs) begin
                r_wr_ptr <= ptr_next(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end

            case ({w_hs, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: the ID storage has no reset; entries are only read once the count says they are valid.
    always_ff @(posedge clk_i) begin
        if (w_hs) begin
            r_fifo[r_wr_ptr] <= w_sel;
        end
    end

endmodule

// File: doc/obi_mem_arbiter.md
# obi_mem_arbiter

Two-master OBI arbiter that shares one single-port OBI memory between the core's instruction and data ports. It serves, for example, a unified IRAM/DRAM bank that both fetch and load/store reach. It selects one requester per address phase and holds that selection stable until the memory grants. It records the owner of each granted transaction in an in-order ID FIFO and routes each `rvalid`/`rdata` response back to the master that issued it. It sits between the core's OBI ports and an `sp_ram_obi`-class slave in the memory subsystem.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: address width on all ports.
- `DATA_WIDTH`, 32: data width. Byte-enable width is `DATA_WIDTH/8`.
- `MAX_OUTSTANDING`, 2: depth of the ID FIFO, i.e. the maximum number of granted transactions without a response. Range 1..4.

Ports:
- `clk_i` in 1: single clock. All state updates on its rising edge.
- `rst_i` in 1: reset. Synchronous, active-high.
- `insn_req_i` in 1, `insn_gnt_o` out 1, `insn_addr_i` in ADDR_WIDTH: instruction master (M0) address phase, read-only.
- `insn_rvalid_o` out 1, `insn_rdata_o` out DATA_WIDTH: M0 response phase.
- `data_req_i` in 1, `data_gnt_o` out 1, `data_addr_i` in ADDR_WIDTH: data master (M1) address phase.
- `data_we_i` in 1, `data_be_i` in DATA_WIDTH/8, `data_wdata_i` in DATA_WIDTH: M1 write controls.
- `data_rvalid_o` out 1, `data_rdata_o` out DATA_WIDTH: M1 response phase.
- `mem_req_o` out 1, `mem_gnt_i` in 1, `mem_addr_o` out ADDR_WIDTH: slave address phase.
- `mem_we_o` out 1, `mem_be_o` out DATA_WIDTH/8, `mem_wdata_o` out DATA_WIDTH: slave write controls.
- `mem_rvalid_i` in 1, `mem_rdata_i` in DATA_WIDTH: slave response phase.

## Operation
Arbitration:
- `full` = (outstanding count == MAX_OUTSTANDING).
- `mem_req_o` = (insn_req_i | data_req_i) & ~full.
- When the lock is clear, the arbitration policy chooses the selected master `sel`.
- When the lock is set, `sel` = `lock_id`.

Multiplexing:
- `mem_addr_o`, `mem_we_o`, `mem_be_o` and `mem_wdata_o` are muxed from `sel`.
- For M0: `mem_we_o`=0, `mem_be_o`=all ones, `mem_wdata_o`=0.

Lock (sequential):
- Set condition: `mem_req_o` & ~`mem_gnt_i`. On this edge, `lock_id` <= `sel`.
- Clear condition: handshake (`mem_req_o` & `mem_gnt_i`).
- While the lock is set, selection never changes, even if the other master raises `req`.
- This keeps the slave address phase stable.

Grant:
- `insn_gnt_o` = `mem_gnt_i` & `mem_req_o` & (sel==M0).
- `data_gnt_o` is the same term with M1.
- The non-selected master always sees `gnt`=0.

ID FIFO:
- Push the 1-bit `sel` on handshake. Pop on `mem_rvalid_i`.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- A pop does not clear `full` within the same cycle. A new request waits one cycle.
- Pointers wrap modulo MAX_OUTSTANDING.

Response routing:
- `insn_rvalid_o` = `mem_rvalid_i` & ~empty & (head==M0).
- `data_rvalid_o` is the same term with (head==M1).
- Both `rdata` outputs are driven with `mem_rdata_i` unconditionally.
- A `mem_rvalid_i` while the FIFO is empty is dropped: no output pulses and no state change.

## Timing
- Address and grant paths are combinational. A transaction is accepted in the same cycle the slave grants.
- Response path is combinational: `rvalid` reaches the master in the same cycle as `mem_rvalid_i`. The arbiter adds 0 cycles of latency.
- Reset state: FIFO empty, count=0, lock clear, round-robin pointer favours M0.
  - With masters idle, every output is 0, including `mem_req_o`, both `gnt` and both `rvalid`.
- Reset asserted mid-transaction:
  - Lock, FIFO and count clear at the next edge.
  - Responses still in flight from the slave are dropped, as for an empty FIFO.
  - The slave must be reset together with the arbiter.
- Back-to-back traffic:
  - One handshake per cycle is possible while not full.
  - Sustained throughput with MAX_OUTSTANDING=2 and a slave with 1-cycle `rvalid` is 1 transaction per cycle.

## Configuration
- `OBI_ARB_ROUND_ROBIN_EN` defined: round-robin arbitration.
  - A pointer register `last` is updated to the granted master on each handshake.
  - On a conflict with the lock clear, the master other than `last` wins.
  - After reset, M0 wins the first conflict.
- Macro undefined: fixed priority, data (M1) over instruction (M0).
  - No `last` register is synthesized.
  - M0 can starve while M1 requests continuously. This is accepted behaviour.

## Test plan
- Single M0 read to 0x0000_0010, slave grants immediately, `rvalid` next cycle with 0xDEAD_BEEF -> `insn_gnt_o` pulses in cycle 0, `insn_rvalid_o` pulses in cycle 1 with 0xDEAD_BEEF, `data_rvalid_o` stays 0.
- Both masters request every cycle for 8 cycles, slave always grants:
  - Round-robin build: grants alternate M0, M1, M0, ….
  - Fixed build: 8 consecutive `data_gnt_o` and 0 `insn_gnt_o`.
- M1 write (be=0x3, wdata=0x1234_5678) with `mem_gnt_i` held low for 3 cycles while M0 raises `req` in cycle 1 -> `mem_addr_o`/`mem_we_o`/`mem_be_o` stay on M1 for all 4 cycles, M1 is granted in cycle 3, then M0 is granted.
- MAX_OUTSTANDING=2, slave grants 2 requests and withholds `rvalid` -> `mem_req_o`=0 while full. Next handshake occurs 1 cycle after the first `rvalid`. Responses return in issue order to the correct masters.
- Spurious `mem_rvalid_i` with the FIFO empty -> no `rvalid` output, count stays 0.
- `rst_i` asserted with 2 outstanding and the lock set -> next cycle count=0, lock clear, all outputs 0 while masters are idle.
